// File: rtl/cdc_sync_bus_pkg.sv
// Shared constants and helpers for the cdc_sync_bus synchroniser family.
// Stage-depth limits and the filter counter width live here.
package cdc_pkg;

  localparam int CDC_MIN_STAGES     = 2;
  localparam int CDC_MAX_STAGES     = 8;
  localparam int CDC_DEFAULT_STAGES = 3;

  function automatic int cdc_cnt_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/cdc_sync_filter.sv
// One channel: optional stability filter, output register and edge history.
// The stability filter is built only when CDC_SYNC_FILTER_EN is defined.
module cdc_sync_filter
  import cdc_pkg::*;
#(
  parameter int   FILTER_LEN = 4,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic prev;

  if (FILTER_LEN < 1) begin : g_bad_len
    $error("cdc_sync_filter: FILTER_LEN must be >= 1");
  end

`ifdef CDC_SYNC_FILTER_EN
  localparam int CW = cdc_cnt_w(FILTER_LEN);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic [CW-1:0] cnt;

  // Output moves only after s has disagreed for FILTER_LEN edges in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sync <= RESET_VAL;
    end else if (s == sync) begin
      cnt  <= '0;
    end else if (cnt == LAST) begin
      sync <= s;
      cnt  <= '0;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= RESET_VAL;
    else     sync <= s;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= RESET_VAL;
    else     prev <= sync;
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/cdc_sync_bus.sv
// WIDTH independent level synchronisers with per-channel edge pulses.
// Optional glitch filter enabled by defining CDC_SYNC_FILTER_EN.
module cdc_sync_bus
  import cdc_pkg::*;
#(
  parameter int               WIDTH      = 1,
  parameter int               STAGES     = CDC_DEFAULT_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter int               FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  if (STAGES < CDC_MIN_STAGES || STAGES > CDC_MAX_STAGES) begin : g_bad_stages
    $error("cdc_sync_bus: STAGES must be in 2..8");
  end

  // Pure flop chain, nothing between stages, kept together for placement.
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) stage[k] <= RESET_VAL;
    end else begin
      stage[0] <= i_async;
      for (int k = 1; k < STAGES; k++) stage[k] <= stage[k-1];
    end
  end

  for (genvar ch = 0; ch < WIDTH; ch++) begin : g_ch
    cdc_sync_filter #(
      .FILTER_LEN(FILTER_LEN),
      .RESET_VAL (RESET_VAL[ch])
    ) u_filt (
      .clk (clk),
      .rst (rst),
      .s   (stage[STAGES-1][ch]),
      .sync(o_sync[ch]),
      .rise(o_rise[ch]),
      .fall(o_fall[ch])
    );
  end

endmodule

// File: tb/tb_cdc_sync_bus.sv
// Directed-vector bench for cdc_sync_bus (filtered and unfiltered builds).
module tb_cdc_sync_bus;

  localparam int W  = 4;
  localparam int ST = 3;
  localparam int FL = 4;
`ifdef CDC_SYNC_FILTER_EN
  localparam int XL = FL - 1;
`else
  localparam int XL = 0;
`endif
  // Row where a step driven in row 0 first shows on o_sync.
  localparam int LAT = ST + XL;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a   = 4'hF;
  logic [W-1:0] sy, ri, fa;
  logic         a2 = 1'b0, a5 = 1'b0;
  logic         s2, r2, f2, s5, r5, f5;

  always #5 clk = ~clk;

  cdc_sync_bus #(.WIDTH(W), .STAGES(ST), .RESET_VAL('0), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst(rst), .i_async(a),
    .o_sync(sy), .o_rise(ri), .o_fall(fa)
  );

  cdc_sync_bus #(.WIDTH(1), .STAGES(2), .RESET_VAL(1'b0), .FILTER_LEN(FL)) dut2 (
    .clk(clk), .rst(rst), .i_async(a2),
    .o_sync(s2), .o_rise(r2), .o_fall(f2)
  );

  cdc_sync_bus #(.WIDTH(1), .STAGES(5), .RESET_VAL(1'b0), .FILTER_LEN(FL)) dut5 (
    .clk(clk), .rst(rst), .i_async(a5),
    .o_sync(s5), .o_rise(r5), .o_fall(f5)
  );

  typedef struct packed {
    logic [3:0] din;
    logic [3:0] dsy;
    logic [3:0] dri;
    logic [3:0] dfa;
  } vec_t;

  vec_t tv[$];
  int total = 0;
  int bad   = 0;

  function automatic void push(logic [3:0] i, logic [3:0] s,
                               logic [3:0] r, logic [3:0] f, int n);
    for (int k = 0; k < n; k++) tv.push_back('{din: i, dsy: s, dri: r, dfa: f});
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string nm, input logic [3:0] s,
                      input logic [3:0] r, input logic [3:0] f);
    chk({nm, ".sync"}, sy, s);
    chk({nm, ".rise"}, ri, r);
    chk({nm, ".fall"}, fa, f);
  endtask

  task automatic sweep(input int stg, input bit use5);
    int first, nrise, rrow;
    first = -1; nrise = 0; rrow = -1;
    for (int r = 0; r < 16; r++) begin
      cyc();
      if (first < 0 && (use5 ? s5 : s2)) first = r;
      if (use5 ? r5 : r2) begin
        nrise++;
        rrow = r;
      end
    end
    chki($sformatf("lat%0d.first", stg), first, stg + XL);
    chki($sformatf("lat%0d.nrise", stg), nrise, 1);
    chki($sformatf("lat%0d.rrow", stg), rrow, stg + XL);
  endtask

  initial begin
`ifdef CDC_SYNC_FILTER_EN
    push(4'h0, 4'hF, 4'h0, 4'h0, 6);
    push(4'h0, 4'h0, 4'h0, 4'hF, 1);
    push(4'h0, 4'h0, 4'h0, 4'h0, 3);
    push(4'h2, 4'h0, 4'h0, 4'h0, 3);
    push(4'h0, 4'h0, 4'h0, 4'h0, 7);
    push(4'h2, 4'h0, 4'h0, 4'h0, 4);
    push(4'h0, 4'h0, 4'h0, 4'h0, 2);
    push(4'h0, 4'h2, 4'h2, 4'h0, 1);
    push(4'h0, 4'h2, 4'h0, 4'h0, 3);
    push(4'h0, 4'h0, 4'h0, 4'h2, 1);
    push(4'h0, 4'h0, 4'h0, 4'h0, 5);
    for (int k = 0; k < 12; k++) begin
      push(4'h4, 4'h0, 4'h0, 4'h0, 2);
      push(4'h0, 4'h0, 4'h0, 4'h0, 2);
    end
    push(4'h4, 4'h0, 4'h0, 4'h0, 6);
    push(4'h4, 4'h4, 4'h4, 4'h0, 1);
    push(4'h4, 4'h4, 4'h0, 4'h0, 3);
`else
    push(4'hE, 4'hF, 4'h0, 4'h0, 3);
    push(4'hC, 4'hE, 4'h0, 4'h1, 1);
    push(4'hC, 4'hE, 4'h0, 4'h0, 1);
    push(4'h5, 4'hE, 4'h0, 4'h0, 1);
    push(4'h5, 4'hC, 4'h0, 4'h2, 1);
    push(4'hA, 4'hC, 4'h0, 4'h0, 1);
    push(4'hA, 4'h5, 4'h1, 4'h8, 1);
    push(4'hA, 4'h5, 4'h0, 4'h0, 1);
    push(4'h0, 4'hA, 4'hA, 4'h5, 1);
    push(4'h0, 4'hA, 4'h0, 4'h0, 2);
    push(4'h0, 4'h0, 4'h0, 4'hA, 1);
    push(4'h0, 4'h0, 4'h0, 4'h0, 2);
    push(4'h1, 4'h0, 4'h0, 4'h0, 1);
    push(4'h0, 4'h0, 4'h0, 4'h0, 2);
    push(4'h0, 4'h1, 4'h1, 4'h0, 1);
    push(4'h4, 4'h0, 4'h0, 4'h1, 1);
    push(4'h4, 4'h0, 4'h0, 4'h0, 2);
    push(4'h4, 4'h4, 4'h4, 4'h0, 1);
    push(4'h4, 4'h4, 4'h0, 4'h0, 1);
`endif

    // Held in reset with all inputs high.
    for (int r = 0; r < 3; r++) begin
      cyc();
      chk3($sformatf("rst%0d", r), 4'h0, 4'h0, 4'h0);
    end

    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r <= LAT + 1; r++) begin
      cyc();
      chk3($sformatf("rel%0d", r), (r >= LAT) ? 4'hF : 4'h0,
           (r == LAT) ? 4'hF : 4'h0, 4'h0);
    end

    foreach (tv[n]) begin
      a = tv[n].din;
      cyc();
      chk3($sformatf("vec%0d", n), tv[n].dsy, tv[n].dri, tv[n].dfa);
    end

    // Reset in the middle of a transition in flight (filter count at 2).
    a = 4'hC;
    for (int r = 0; r < LAT - 1; r++) begin
      cyc();
      chk($sformatf("pre%0d.sync", r), sy, 4'h4);
    end
    rst = 1'b1;
    #1;
    chk3("async_rst", 4'h0, 4'h0, 4'h0);
    cyc();
    chk3("in_rst", 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r <= LAT + 1; r++) begin
      cyc();
      chk3($sformatf("rel2_%0d", r), (r >= LAT) ? 4'hC : 4'h0,
           (r == LAT) ? 4'hC : 4'h0, 4'h0);
    end

    a2 = 1'b1;
    a5 = 1'b1;
    fork
      sweep(2, 1'b0);
      sweep(5, 1'b1);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
